axin_alloc_mux: RTL and testbench
=================================

Name: axin_alloc_mux

Overview:
- Per-output-port arbiter and multiplexer that sits directly downstream of the broadcast stage.
- Each of NIN broadcasters raises a channel request on this port. The block grants exactly one of them (round-robin) via ALLOC, then forwards that source's AXIN packet stream onto a single registered output.
- A FIFO or the port's TX path follows. One instance exists per switch output port.

Parameters:
- NIN, 4, number of requesting sources (broadcaster instances).
- DW, 64, data bits per beat.
- WBITS, $clog2(DW/8), width of the BYTES field.
- OPT_LOWPOWER, 0, when set, M_DATA/M_BYTES/M_LAST are forced to zero whenever M_VALID is low.

Ports:
- i_clk  input  1  system clock; the block uses this single clock.
- i_reset  input  1  synchronous, active-high reset.
- i_cfg_active  input  1  output port enabled.
- S_CHREQ  input  NIN  per-source channel request.
- S_ALLOC  output  NIN  per-source grant; one-hot or zero.
- S_VALID  input  NIN  per-source beat valid.
- S_READY  output  NIN  per-source beat ready.
- S_DATA  input  NIN*DW  per-source data, source k at [k*DW +: DW].
- S_BYTES  input  NIN*WBITS  per-source valid-byte count, 0 = full beat.
- S_LAST  input  NIN  per-source last beat of packet.
- S_ABORT  input  NIN  per-source packet abort.
- M_VALID  output  1  output beat valid.
- M_READY  input  1  output beat ready.
- M_DATA  output  DW  output data.
- M_BYTES  output  WBITS  output byte count.
- M_LAST  output  1  output last beat.
- M_ABORT  output  1  output packet abort.

Behaviour:
- Reset: S_ALLOC=0, M_VALID=0, M_ABORT=0, M_LAST=0, M_DATA=0, M_BYTES=0. Round-robin pointer = 0, meaning index 0 has highest priority. State is IDLE.
- State machine has three states:
  - IDLE: no grant is held.
  - GRANT: ALLOC is held and no beat of the packet has been forwarded yet.
  - MIDPKT: at least one non-last beat has been accepted from the granted source.
- IDLE -> GRANT: when i_cfg_active && |S_CHREQ, grant the first requester at or after the pointer, wrapping. S_ALLOC rises on the cycle after S_CHREQ is seen (1-cycle latency). The pointer is set to granted index + 1, mod NIN.
- While a grant is held, S_ALLOC stays asserted as long as S_CHREQ[g] stays high. All other requesters wait.
- GRANT -> MIDPKT: on accepting a beat from source g with !S_LAST.
- MIDPKT -> GRANT: on accepting a beat with S_LAST.
- GRANT or MIDPKT -> IDLE: when S_CHREQ[g] falls.
  - If the fall happens in MIDPKT, raise M_ABORT.
  - A new grant can be issued no earlier than the cycle after IDLE is entered (one dead cycle minimum).
- S_READY[k] = S_ALLOC[k] && i_cfg_active && (!M_VALID || M_READY). Non-granted sources always see S_READY=0.
- Output register loads when !M_VALID || M_READY.
  - M_VALID <= accepted beat from g with !S_ABORT[g].
  - DATA, BYTES and LAST are copied from source g.
  - Throughput is one beat per clock, with 1-cycle latency from S handshake to M_VALID.
- Abort on the granted source, in MIDPKT or with a pending non-last M beat:
  - M_VALID <= 0 and M_ABORT <= 1.
  - M_ABORT clears on the first cycle where (!M_VALID || M_READY), so it lasts one cycle when the output is idle.
  - The state returns to GRANT.
- Abort in GRANT with no beat forwarded: ignored, and M_ABORT stays 0.
- M_ABORT is never raised while M_VALID && M_LAST is pending. A completed packet is not aborted.
- i_cfg_active low: S_ALLOC=0 and M_VALID=0, and state goes to IDLE. If in MIDPKT, or if a non-last beat is pending, M_ABORT <= 1.
- Reset mid-packet: all outputs return to reset values on the next edge. No abort is emitted.

Test Plan:
- Single source: S_CHREQ=4'b0001, 3-beat packet (0x11, 0x22, 0x33 with LAST), M_READY=1 -> S_ALLOC[0] one cycle after the request; M emits 0x11, 0x22, 0x33 on consecutive cycles with M_LAST on 0x33; grant released the cycle after S_CHREQ[0] falls.
- Contention: S_CHREQ=4'b1011 held, each source sends a 1-beat packet then drops its request -> grants issued in order 0, 1, 3, 0, with a one-cycle IDLE gap between grants.
- Backpressure: M_READY toggled 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; S_READY[g] low while M_VALID && !M_READY; M_DATA stable while stalled.
- Mid-packet abort: S_ABORT[2] after 2 beats -> pending beat dropped, M_ABORT=1 for one cycle, M_VALID=0; a subsequent packet from source 2 flows normally.
- Request withdrawn: S_CHREQ[1] drops after 1 non-last beat -> M_ABORT pulses; S_ALLOC returns to 0 and the next requester is granted 2 cycles later.
- Port disabled: i_cfg_active falls in MIDPKT -> M_ABORT=1 and S_ALLOC=0; no new grant is issued while inactive; with OPT_LOWPOWER=1, M_DATA=0 whenever M_VALID=0.

Source files
------------

// File: rtl/axin_alloc_mux.sv
// -----------------------------------------------------------------------------
// axin_alloc_mux
//
// Per-output-port arbiter and packet multiplexer placed directly behind the
// broadcast stage. Each of NIN broadcasters raises a channel request; one of
// them is granted round-robin through S_ALLOC, and the granted source's AXIN
// beat stream is forwarded through a single output register.
//
// Ports:
//   i_clk, i_reset      single clock, synchronous active-high reset
//   i_cfg_active        output port enabled; when low, grants are dropped
//   S_CHREQ/S_ALLOC     per-source channel request / one-hot (or zero) grant
//   S_VALID/S_READY     per-source beat handshake
//   S_DATA/S_BYTES      per-source beat payload, source k at [k*W +: W]
//   S_LAST/S_ABORT      per-source end-of-packet / packet abort
//   M_VALID/M_READY     output beat handshake (registered valid)
//   M_DATA/M_BYTES      output beat payload (registered)
//   M_LAST/M_ABORT      output end-of-packet / one-shot abort (registered)
// -----------------------------------------------------------------------------
module axin_alloc_mux #(
    parameter int NIN          = 4,
    parameter int DW           = 64,
    parameter int WBITS        = $clog2(DW / 8),
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cfg_active,
    input  logic [NIN-1:0]         S_CHREQ,
    output logic [NIN-1:0]         S_ALLOC,
    input  logic [NIN-1:0]         S_VALID,
    output logic [NIN-1:0]         S_READY,
    input  logic [NIN*DW-1:0]      S_DATA,
    input  logic [NIN*WBITS-1:0]   S_BYTES,
    input  logic [NIN-1:0]         S_LAST,
    input  logic [NIN-1:0]         S_ABORT,
    output logic                   M_VALID,
    input  logic                   M_READY,
    output logic [DW-1:0]          M_DATA,
    output logic [WBITS-1:0]       M_BYTES,
    output logic                   M_LAST,
    output logic                   M_ABORT
);

    localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_MIDPKT = 2'd2
    } state_t;

    state_t             state_r, state_n, after_s;
    logic [IW-1:0]      grant_r, grant_n;
    logic [IW-1:0]      ptr_r, ptr_n;
    logic [NIN-1:0]     alloc_r, alloc_n;
    logic               m_valid_r, m_valid_n;
    logic [DW-1:0]      m_data_r, m_data_n;
    logic [WBITS-1:0]   m_bytes_r, m_bytes_n;
    logic               m_last_r, m_last_n;
    logic               m_abort_r, m_abort_n;

    logic               load_s;
    logic               fire_s;
    logic               open_s;
    logic               withdraw_abort_s;
    logic [NIN-1:0]     ready_s;
    logic [IW-1:0]      pick_s;
    logic               g_valid_s;
    logic               g_last_s;
    logic               g_abort_s;
    logic               g_chreq_s;
    logic [DW-1:0]      g_data_s;
    logic [WBITS-1:0]   g_bytes_s;

    // First requester at or after ptr, wrapping around NIN.
    function automatic logic [IW-1:0] rr_pick(input logic [NIN-1:0] req,
                                              input logic [IW-1:0]  ptr);
        logic [IW-1:0] sel;
        logic [SW-1:0] sum;
        logic          found;
        sel   = {IW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NIN)) begin
                sum = sum - SW'(NIN);
            end else begin
                sum = sum;
            end
            if (!found && req[sum[IW-1:0]]) begin
                sel   = sum[IW-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // Index + 1 modulo NIN, used to move priority past the granted source.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (idx == IW'(NIN - 1)) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + IW'(1);
        end
        return nxt;
    endfunction

    function automatic logic [NIN-1:0] to_onehot(input logic [IW-1:0] idx);
        logic [NIN-1:0] oh;
        for (int k = 0; k < NIN; k++) begin
            oh[k] = (idx == IW'(k));
        end
        return oh;
    endfunction

    // Granted-source view of the request/beat inputs.
    assign g_valid_s = S_VALID[grant_r];
    assign g_last_s  = S_LAST[grant_r];
    assign g_abort_s = S_ABORT[grant_r];
    assign g_chreq_s = S_CHREQ[grant_r];
    assign g_data_s  = S_DATA[int'(grant_r) * DW +: DW];
    assign g_bytes_s = S_BYTES[int'(grant_r) * WBITS +: WBITS];

    assign pick_s  = rr_pick(S_CHREQ, ptr_r);
    assign load_s  = !m_valid_r || M_READY;
    assign ready_s = alloc_r & {NIN{i_cfg_active && load_s}};
    assign fire_s  = (state_r != ST_IDLE) && g_valid_s && ready_s[grant_r];
    // A packet is open once a non-last beat has left the source; only an open
    // packet can be aborted, so a completed packet never sees M_ABORT.
    assign open_s  = (state_r == ST_MIDPKT) || (m_valid_r && !m_last_r);

    // Next-state, grant and output-register load logic.
    always_comb begin
        state_n          = state_r;
        grant_n          = grant_r;
        ptr_n            = ptr_r;
        alloc_n          = alloc_r;
        m_data_n         = m_data_r;
        m_bytes_n        = m_bytes_r;
        m_last_n         = m_last_r;
        after_s          = state_r;
        withdraw_abort_s = 1'b0;

        // A consumed beat or a finished abort pulse leaves the register.
        if (load_s) begin
            m_valid_n = 1'b0;
            m_abort_n = 1'b0;
        end else begin
            m_valid_n = m_valid_r;
            m_abort_n = m_abort_r;
        end

        if (!i_cfg_active) begin
            state_n   = ST_IDLE;
            alloc_n   = {NIN{1'b0}};
            m_valid_n = 1'b0;
            if (open_s) begin
                m_abort_n = 1'b1;
            end else begin
                m_abort_n = load_s ? 1'b0 : m_abort_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|S_CHREQ) begin
                        grant_n = pick_s;
                        alloc_n = to_onehot(pick_s);
                        ptr_n   = wrap_inc(pick_s);
                        state_n = ST_GRANT;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_GRANT, ST_MIDPKT: begin
                    if (g_abort_s && open_s) begin
                        // Drop any pending partial beat and signal the abort.
                        m_valid_n = 1'b0;
                        m_abort_n = 1'b1;
                        after_s   = ST_GRANT;
                    end else if (fire_s && !g_abort_s) begin
                        m_valid_n = 1'b1;
                        m_data_n  = g_data_s;
                        m_bytes_n = g_bytes_s;
                        m_last_n  = g_last_s;
                        after_s   = g_last_s ? ST_GRANT : ST_MIDPKT;
                    end else begin
                        // Covers an abort-flagged beat before anything was
                        // forwarded: it is consumed and silently discarded.
                        after_s = state_r;
                    end

                    if (!g_chreq_s) begin
                        // Losing the channel with a packet still open aborts it.
                        state_n          = ST_IDLE;
                        alloc_n          = {NIN{1'b0}};
                        withdraw_abort_s = (after_s == ST_MIDPKT);
                    end else begin
                        state_n = after_s;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    alloc_n = {NIN{1'b0}};
                end
            endcase
        end

        if (withdraw_abort_s) begin
            m_valid_n = 1'b0;
            m_abort_n = 1'b1;
        end else begin
            m_abort_n = m_abort_n;
        end

        if (OPT_LOWPOWER && !m_valid_n) begin
            m_data_n  = {DW{1'b0}};
            m_bytes_n = {WBITS{1'b0}};
            m_last_n  = 1'b0;
        end else begin
            m_last_n  = m_last_n;
        end
    end

    // State, arbitration and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= {IW{1'b0}};
            ptr_r     <= {IW{1'b0}};
            alloc_r   <= {NIN{1'b0}};
            m_valid_r <= 1'b0;
            m_data_r  <= {DW{1'b0}};
            m_bytes_r <= {WBITS{1'b0}};
            m_last_r  <= 1'b0;
            m_abort_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            grant_r   <= grant_n;
            ptr_r     <= ptr_n;
            alloc_r   <= alloc_n;
            m_valid_r <= m_valid_n;
            m_data_r  <= m_data_n;
            m_bytes_r <= m_bytes_n;
            m_last_r  <= m_last_n;
            m_abort_r <= m_abort_n;
        end
    end

    assign S_ALLOC = alloc_r;
    assign S_READY = ready_s;
    assign M_VALID = m_valid_r;
    assign M_DATA  = m_data_r;
    assign M_BYTES = m_bytes_r;
    assign M_LAST  = m_last_r;
    assign M_ABORT = m_abort_r;

endmodule

// File: tb/tb_axin_alloc_mux.sv
// -----------------------------------------------------------------------------
// tb_axin_alloc_mux
//
// Directed bench for axin_alloc_mux (NIN=4, DW=64, OPT_LOWPOWER=1). Inputs are
// driven on the falling edge, registered outputs are checked on the following
// falling edge; combinational S_READY is checked 1 time unit after driving.
// -----------------------------------------------------------------------------
module tb_axin_alloc_mux;

    localparam int NIN   = 4;
    localparam int DW    = 64;
    localparam int WBITS = 3;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic                 i_cfg_active;
    logic [NIN-1:0]       s_chreq;
    logic [NIN-1:0]       s_alloc;
    logic [NIN-1:0]       s_valid;
    logic [NIN-1:0]       s_ready;
    logic [NIN*DW-1:0]    s_data;
    logic [NIN*WBITS-1:0] s_bytes;
    logic [NIN-1:0]       s_last;
    logic [NIN-1:0]       s_abort;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_data;
    logic [WBITS-1:0]     m_bytes;
    logic                 m_last;
    logic                 m_abort;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axin_alloc_mux #(
        .NIN          (NIN),
        .DW           (DW),
        .WBITS        (WBITS),
        .OPT_LOWPOWER (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cfg_active (i_cfg_active),
        .S_CHREQ      (s_chreq),
        .S_ALLOC      (s_alloc),
        .S_VALID      (s_valid),
        .S_READY      (s_ready),
        .S_DATA       (s_data),
        .S_BYTES      (s_bytes),
        .S_LAST       (s_last),
        .S_ABORT      (s_abort),
        .M_VALID      (m_valid),
        .M_READY      (m_ready),
        .M_DATA       (m_data),
        .M_BYTES      (m_bytes),
        .M_LAST       (m_last),
        .M_ABORT      (m_abort)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input int k, input logic v, input logic [DW-1:0] d,
                        input logic [WBITS-1:0] b, input logic l);
        s_valid[k]               = v;
        s_data[k*DW +: DW]       = d;
        s_bytes[k*WBITS +: WBITS] = b;
        s_last[k]                = l;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_cfg_active = 1'b1;
        s_chreq      = 4'b0000;
        s_valid      = 4'b0000;
        s_data       = '0;
        s_bytes      = '0;
        s_last       = 4'b0000;
        s_abort      = 4'b0000;
        m_ready      = 1'b1;
        cyc();
        cyc();
        i_reset = 1'b0;

        // Reset values
        check("rst_alloc", s_alloc, 4'b0000);
        check("rst_mvalid", m_valid, 1'b0);
        check("rst_mabort", m_abort, 1'b0);
        check("rst_mlast", m_last, 1'b0);
        check("rst_mdata", m_data, 64'h0);
        check("rst_mbytes", m_bytes, 3'd0);

        // Single source, 3-beat packet
        s_chreq = 4'b0001;
        cyc();
        check("t1_alloc", s_alloc, 4'b0001);
        check("t1_mvalid_idle", m_valid, 1'b0);
        beat(0, 1'b1, 64'h11, 3'd0, 1'b0);
        #1;
        check("t1_sready", s_ready, 4'b0001);
        cyc();
        check("t1_b1_valid", m_valid, 1'b1);
        check("t1_b1_data", m_data, 64'h11);
        check("t1_b1_last", m_last, 1'b0);
        beat(0, 1'b1, 64'h22, 3'd0, 1'b0);
        cyc();
        check("t1_b2_data", m_data, 64'h22);
        beat(0, 1'b1, 64'h33, 3'd5, 1'b1);
        cyc();
        check("t1_b3_data", m_data, 64'h33);
        check("t1_b3_last", m_last, 1'b1);
        check("t1_b3_bytes", m_bytes, 3'd5);
        beat(0, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b0000;
        cyc();
        check("t1_release", s_alloc, 4'b0000);
        check("t1_mvalid_end", m_valid, 1'b0);
        check("t1_lowpower", m_data, 64'h0);
        check("t1_noabort", m_abort, 1'b0);

        // Contention, pointer restarted at 0
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        s_chreq = 4'b1011;
        cyc();
        check("t2_g0", s_alloc, 4'b0001);
        beat(0, 1'b1, 64'hA0, 3'd0, 1'b1);
        cyc();
        check("t2_d0", m_data, 64'hA0);
        check("t2_d0_last", m_last, 1'b1);
        beat(0, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b1010;
        cyc();
        check("t2_gap0", s_alloc, 4'b0000);
        s_chreq = 4'b1011;
        cyc();
        check("t2_g1", s_alloc, 4'b0010);
        beat(0, 1'b1, 64'hBAD0, 3'd0, 1'b1);
        beat(1, 1'b1, 64'hB1, 3'd0, 1'b1);
        beat(3, 1'b1, 64'hBAD3, 3'd0, 1'b1);
        #1;
        check("t2_ready_only_g", s_ready, 4'b0010);
        cyc();
        check("t2_d1", m_data, 64'hB1);
        beat(0, 1'b0, 64'h0, 3'd0, 1'b0);
        beat(1, 1'b0, 64'h0, 3'd0, 1'b0);
        beat(3, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b1001;
        cyc();
        check("t2_gap1", s_alloc, 4'b0000);
        s_chreq = 4'b1011;
        cyc();
        check("t2_g3", s_alloc, 4'b1000);
        beat(3, 1'b1, 64'hC3, 3'd0, 1'b1);
        cyc();
        check("t2_d3", m_data, 64'hC3);
        beat(3, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b0011;
        cyc();
        check("t2_gap3", s_alloc, 4'b0000);
        s_chreq = 4'b1011;
        cyc();
        check("t2_g0_again", s_alloc, 4'b0001);
        s_chreq = 4'b0000;
        cyc();

        // Backpressure on a 4-beat packet from source 1
        s_chreq = 4'b0010;
        cyc();
        check("t3_g1", s_alloc, 4'b0010);
        beat(1, 1'b1, 64'hD1, 3'd0, 1'b0);
        cyc();
        check("t3_d1", m_data, 64'hD1);
        beat(1, 1'b1, 64'hD2, 3'd0, 1'b0);
        #1;
        check("t3_ready_go", s_ready, 4'b0010);
        cyc();
        check("t3_d2", m_data, 64'hD2);
        beat(1, 1'b1, 64'hD3, 3'd0, 1'b0);
        m_ready = 1'b0;
        #1;
        check("t3_ready_stall1", s_ready, 4'b0000);
        cyc();
        check("t3_hold1_data", m_data, 64'hD2);
        check("t3_hold1_valid", m_valid, 1'b1);
        check("t3_ready_stall2", s_ready, 4'b0000);
        cyc();
        check("t3_hold2_data", m_data, 64'hD2);
        m_ready = 1'b1;
        #1;
        check("t3_ready_resume", s_ready, 4'b0010);
        cyc();
        check("t3_d3", m_data, 64'hD3);
        beat(1, 1'b1, 64'hD4, 3'd0, 1'b1);
        cyc();
        check("t3_d4", m_data, 64'hD4);
        check("t3_d4_last", m_last, 1'b1);
        beat(1, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b0000;
        cyc();
        check("t3_end_valid", m_valid, 1'b0);

        // Mid-packet abort from source 2
        s_chreq = 4'b0100;
        cyc();
        check("t4_g2", s_alloc, 4'b0100);
        beat(2, 1'b1, 64'hE1, 3'd0, 1'b0);
        cyc();
        beat(2, 1'b1, 64'hE2, 3'd0, 1'b0);
        cyc();
        check("t4_e2", m_data, 64'hE2);
        beat(2, 1'b0, 64'h0, 3'd0, 1'b0);
        s_abort = 4'b0100;
        m_ready = 1'b0;
        cyc();
        check("t4_abort", m_abort, 1'b1);
        check("t4_drop_valid", m_valid, 1'b0);
        s_abort = 4'b0000;
        m_ready = 1'b1;
        cyc();
        check("t4_abort_clear", m_abort, 1'b0);
        check("t4_still_granted", s_alloc, 4'b0100);
        s_abort = 4'b0100;
        cyc();
        check("t4_abort_in_grant_ignored", m_abort, 1'b0);
        s_abort = 4'b0000;
        beat(2, 1'b1, 64'hF1, 3'd0, 1'b1);
        cyc();
        check("t4_next_pkt", m_data, 64'hF1);
        check("t4_next_valid", m_valid, 1'b1);
        beat(2, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b0000;
        cyc();

        // Request withdrawn mid-packet from source 1
        s_chreq = 4'b0010;
        cyc();
        check("t5_g1", s_alloc, 4'b0010);
        beat(1, 1'b1, 64'h61, 3'd0, 1'b0);
        s_chreq = 4'b1010;
        cyc();
        check("t5_g1_held", s_alloc, 4'b0010);
        beat(1, 1'b0, 64'h0, 3'd0, 1'b0);
        s_chreq = 4'b1000;
        cyc();
        check("t5_abort", m_abort, 1'b1);
        check("t5_alloc_drop", s_alloc, 4'b0000);
        check("t5_valid_drop", m_valid, 1'b0);
        cyc();
        check("t5_g3", s_alloc, 4'b1000);
        check("t5_abort_clear", m_abort, 1'b0);

        // Port disabled mid-packet
        beat(3, 1'b1, 64'h71, 3'd0, 1'b0);
        cyc();
        check("t6_h1", m_data, 64'h71);
        beat(3, 1'b0, 64'h0, 3'd0, 1'b0);
        i_cfg_active = 1'b0;
        cyc();
        check("t6_abort", m_abort, 1'b1);
        check("t6_alloc", s_alloc, 4'b0000);
        check("t6_valid", m_valid, 1'b0);
        check("t6_lowpower", m_data, 64'h0);
        cyc();
        check("t6_no_grant1", s_alloc, 4'b0000);
        check("t6_abort_clear", m_abort, 1'b0);
        cyc();
        check("t6_no_grant2", s_alloc, 4'b0000);
        i_cfg_active = 1'b1;
        cyc();
        check("t6_regrant", s_alloc, 4'b1000);

        // Reset mid-packet: no abort, everything back to reset values
        beat(3, 1'b1, 64'h81, 3'd0, 1'b0);
        cyc();
        check("t7_j1", m_data, 64'h81);
        beat(3, 1'b0, 64'h0, 3'd0, 1'b0);
        i_reset = 1'b1;
        cyc();
        check("t7_valid", m_valid, 1'b0);
        check("t7_abort", m_abort, 1'b0);
        check("t7_alloc", s_alloc, 4'b0000);
        check("t7_data", m_data, 64'h0);
        i_reset = 1'b0;
        s_chreq = 4'b0000;
        cyc();
        check("t7_idle", s_alloc, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
